grf_wb_port: RTL and testbench

Write-back port driver that sits between the pipeline's write sources and the general register file's single write port (regwrite/wa/wd). It merges the W-stage write stream with a secondary, long-latency producer (MDU / multi-cycle results) behind a valid/ready handshake, buffering secondary writes in a small FIFO and draining them into idle write-port cycles. It also exports a per-register busy mask so the hazard unit can stall readers of registers with queued writes.

---
 rtl/grf_wb_port.sv | 189 ++++++++++++++++++
 tb/tb_grf_wb_port.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_port.sv
// grf_wb_port
// Write-back port driver for the general register file's single write port.
// The W-stage stream always wins the port. A secondary long-latency producer
// hands in writes over valid/ready; these are buffered in a small FIFO and
// drained into cycles where W does not write. A queued entry whose
// destination is overwritten by a W write is squashed, because W is younger.
// A squashed entry stays in the FIFO and occupies one idle slot when it
// drains, but it never reaches the port.
//
// Ports
//   clk, rst           clock (rising edge); asynchronous active-low reset
//   w_we/w_wa/w_wd/w_pc W-stage write (no backpressure)
//   s_valid/s_ready    secondary handshake; s_wa/s_wd/s_pc are the payload
//   regwrite/wa/wd/wpc registered GRF write port plus trace PC
//   busy               bit i set while a live queued write targets $i
//   count              FIFO occupancy, counting live and squashed entries
module grf_wb_port #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_we,
   input  logic [4:0]               w_wa,
   input  logic [31:0]              w_wd,
   input  logic [31:0]              w_pc,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [4:0]               s_wa,
   input  logic [31:0]              s_wd,
   input  logic [31:0]              s_pc,
   output logic                     regwrite,
   output logic [4:0]               wa,
   output logic [31:0]              wd,
   output logic [31:0]              wpc,
   output logic [31:0]              busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // FIFO storage and pointers
   logic              ent_live_q [DEPTH];
   logic              ent_live_d [DEPTH];
   logic [4:0]        ent_wa_q   [DEPTH];
   logic [4:0]        ent_wa_d   [DEPTH];
   logic [31:0]       ent_wd_q   [DEPTH];
   logic [31:0]       ent_wd_d   [DEPTH];
   logic [31:0]       ent_pc_q   [DEPTH];
   logic [31:0]       ent_pc_d   [DEPTH];
   logic [AW-1:0]     head_q, head_d;
   logic [AW-1:0]     tail_q, tail_d;
   logic [CW-1:0]     count_q, count_d;

   // Port registers
   logic              regwrite_q, regwrite_d;
   logic [4:0]        wa_q, wa_d;
   logic [31:0]       wd_q, wd_d;
   logic [31:0]       wpc_q, wpc_d;

   logic              w_eff_s;
   logic              push_s;
   logic              pop_s;
   logic [31:0]       busy_s;

   // Writes to $0 are dropped at the input; a secondary $0 is still handshaked.
   assign s_ready = (count_q < CW'(DEPTH));
   assign w_eff_s = w_we && (w_wa != 5'd0);
   assign push_s  = s_valid && s_ready && (s_wa != 5'd0);
   assign pop_s   = !w_eff_s && (count_q != {CW{1'b0}});

   // Busy mask: one-hot destination of every live entry. Live bits are cleared
   // on pop, so only occupied slots can contribute.
   always_comb begin
      busy_s = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_live_q[i]) begin
            busy_s = busy_s | (32'd1 << ent_wa_q[i]);
         end else begin
            busy_s = busy_s;
         end
      end
   end

   // FIFO next state: squash by W, pop at head, push at tail
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_wa_d[i] = ent_wa_q[i];
         ent_wd_d[i] = ent_wd_q[i];
         ent_pc_d[i] = ent_pc_q[i];
         if (w_eff_s && (ent_wa_q[i] == w_wa)) begin
            ent_live_d[i] = 1'b0;
         end else begin
            ent_live_d[i] = ent_live_q[i];
         end
      end
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      // Pop never coincides with a W write, so it cannot collide with a squash.
      if (pop_s) begin
         ent_live_d[head_q] = 1'b0;
         head_d             = head_q + AW'(1);
      end else begin
         head_d = head_q;
      end

      // Head and tail slots differ whenever both push and pop happen:
      // pop needs count>0, push needs count<DEPTH.
      if (push_s) begin
         ent_live_d[tail_q] = !(w_eff_s && (s_wa == w_wa));
         ent_wa_d[tail_q]   = s_wa;
         ent_wd_d[tail_q]   = s_wd;
         ent_pc_d[tail_q]   = s_pc;
         tail_d             = tail_q + AW'(1);
      end else begin
         tail_d = tail_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Port next state: W has priority, else a popped head; squashed head idles
   always_comb begin
      regwrite_d = 1'b0;
      wa_d       = wa_q;
      wd_d       = wd_q;
      wpc_d      = wpc_q;
      if (w_eff_s) begin
         regwrite_d = 1'b1;
         wa_d       = w_wa;
         wd_d       = w_wd;
         wpc_d      = w_pc;
      end else if (pop_s && ent_live_q[head_q]) begin
         regwrite_d = 1'b1;
         wa_d       = ent_wa_q[head_q];
         wd_d       = ent_wd_q[head_q];
         wpc_d      = ent_pc_q[head_q];
      end else begin
         regwrite_d = 1'b0;
      end
   end

   // State registers; reset discards all queued entries immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_live_q[i] <= 1'b0;
            ent_wa_q[i]   <= 5'd0;
            ent_wd_q[i]   <= 32'd0;
            ent_pc_q[i]   <= 32'd0;
         end
         head_q     <= {AW{1'b0}};
         tail_q     <= {AW{1'b0}};
         count_q    <= {CW{1'b0}};
         regwrite_q <= 1'b0;
         wa_q       <= 5'd0;
         wd_q       <= 32'd0;
         wpc_q      <= 32'd0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_live_q[i] <= ent_live_d[i];
            ent_wa_q[i]   <= ent_wa_d[i];
            ent_wd_q[i]   <= ent_wd_d[i];
            ent_pc_q[i]   <= ent_pc_d[i];
         end
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         regwrite_q <= regwrite_d;
         wa_q       <= wa_d;
         wd_q       <= wd_d;
         wpc_q      <= wpc_d;
      end
   end

   assign regwrite = regwrite_q;
   assign wa       = wa_q;
   assign wd       = wd_q;
   assign wpc      = wpc_q;
   assign busy     = busy_s;
   assign count    = count_q;

endmodule

// File: tb/tb_grf_wb_port.sv
// Directed testbench for grf_wb_port (DEPTH=4). Inputs change and outputs
// are sampled 1 time unit after each rising clock edge.
module tb_grf_wb_port;

   logic        clk;
   logic        rst;
   logic        w_we;
   logic [4:0]  w_wa;
   logic [31:0] w_wd;
   logic [31:0] w_pc;
   logic        s_valid;
   logic        s_ready;
   logic [4:0]  s_wa;
   logic [31:0] s_wd;
   logic [31:0] s_pc;
   logic        regwrite;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [31:0] wpc;
   logic [31:0] busy;
   logic [2:0]  count;

   int checks;
   int failures;

   grf_wb_port #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd), .w_pc(w_pc),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_wa(s_wa), .s_wd(s_wd), .s_pc(s_pc),
      .regwrite(regwrite), .wa(wa), .wd(wd), .wpc(wpc),
      .busy(busy), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      w_we = 1'b0; w_wa = 5'd0; w_wd = 32'd0; w_pc = 32'd0;
      s_valid = 1'b0; s_wa = 5'd0; s_wd = 32'd0; s_pc = 32'd0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         w_we = 1'($urandom); w_wa = 5'($urandom); w_wd = $urandom; w_pc = $urandom;
         s_valid = 1'($urandom); s_wa = 5'($urandom); s_wd = $urandom; s_pc = $urandom;
         tick();
      end
      checks++; if (regwrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%0b exp=0", regwrite); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy); end
      checks++; if (wa !== 5'd0 || wd !== 32'd0 || wpc !== 32'd0) begin
         failures++; $display("FAIL reset_port got wa=%0d wd=%h wpc=%h exp=0", wa, wd, wpc); end
      idle_inputs();
      rst = 1'b1;
      tick();
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%0b exp=1", s_ready); end
      checks++; if (regwrite !== 1'b0) begin failures++; $display("FAIL reset_idle_regwrite got=%0b exp=0", regwrite); end
   endtask

   task automatic test_w_only();
      w_we = 1'b1; w_wa = 5'd5; w_wd = 32'h1234; w_pc = 32'h3000;
      tick();
      checks++; if (regwrite !== 1'b1 || wa !== 5'd5 || wd !== 32'h1234 || wpc !== 32'h3000) begin
         failures++; $display("FAIL w_only got rw=%0b wa=%0d wd=%h wpc=%h exp rw=1 wa=5 wd=1234 wpc=3000", regwrite, wa, wd, wpc); end
      w_wa = 5'd0; w_wd = 32'hDEAD; w_pc = 32'h3004;
      tick();
      checks++; if (regwrite !== 1'b0 || wa !== 5'd5 || wd !== 32'h1234) begin
         failures++; $display("FAIL w_zero got rw=%0b wa=%0d wd=%h exp rw=0 wa=5 wd=1234", regwrite, wa, wd); end
      idle_inputs();
      tick();
   endtask

   task automatic test_fill_drain();
      logic [31:0] exp_busy [5];
      logic [2:0]  exp_cnt  [5];
      exp_busy[0] = 32'h0E00; exp_busy[1] = 32'h1C00; exp_busy[2] = 32'h1800;
      exp_busy[3] = 32'h1000; exp_busy[4] = 32'h0000;
      exp_cnt[0] = 3'd3; exp_cnt[1] = 3'd3; exp_cnt[2] = 3'd2; exp_cnt[3] = 3'd1; exp_cnt[4] = 3'd0;
      w_we = 1'b1; w_wa = 5'd1; w_wd = 32'h50; w_pc = 32'h4000;
      s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_wa = 5'(8 + i); s_wd = 32'(32'h108 + i); s_pc = 32'(32'h2020 + 4 * i);
         tick();
         checks++; if (count !== 3'(i + 1) || regwrite !== 1'b1 || wa !== 5'd1) begin
            failures++; $display("FAIL fill_%0d got cnt=%0d rw=%0b wa=%0d exp cnt=%0d rw=1 wa=1", i, count, regwrite, wa, i + 1); end
      end
      checks++; if (s_ready !== 1'b0 || busy !== 32'h0F00) begin
         failures++; $display("FAIL full got s_ready=%0b busy=%h exp s_ready=0 busy=00000f00", s_ready, busy); end
      s_wa = 5'd12; s_wd = 32'h10C; s_pc = 32'h2030;
      tick();
      checks++; if (count !== 3'd4 || busy !== 32'h0F00) begin
         failures++; $display("FAIL full_hold got cnt=%0d busy=%h exp cnt=4 busy=00000f00", count, busy); end
      w_we = 1'b0;
      for (int k = 8; k <= 12; k++) begin
         tick();
         if (k == 9) s_valid = 1'b0;
         checks++; if (regwrite !== 1'b1 || wa !== 5'(k) || wd !== 32'(32'h100 + k) || wpc !== 32'(32'h2000 + 4 * k)) begin
            failures++; $display("FAIL drain_%0d got rw=%0b wa=%0d wd=%h wpc=%h", k, regwrite, wa, wd, wpc); end
         checks++; if (count !== exp_cnt[k - 8] || busy !== exp_busy[k - 8]) begin
            failures++; $display("FAIL drain_state_%0d got cnt=%0d busy=%h exp cnt=%0d busy=%h", k, count, busy, exp_cnt[k - 8], exp_busy[k - 8]); end
      end
      tick();
      checks++; if (regwrite !== 1'b0 || wa !== 5'd12) begin
         failures++; $display("FAIL drain_end got rw=%0b wa=%0d exp rw=0 wa=12", regwrite, wa); end
      idle_inputs();
   endtask

   task automatic test_squash();
      s_valid = 1'b1; s_wa = 5'd9; s_wd = 32'hAA; s_pc = 32'h5000;
      w_we = 1'b1; w_wa = 5'd1; w_wd = 32'h11; w_pc = 32'h5100;
      tick();
      checks++; if (count !== 3'd1 || busy !== 32'h0200) begin
         failures++; $display("FAIL squash_queued got cnt=%0d busy=%h exp cnt=1 busy=00000200", count, busy); end
      s_valid = 1'b0;
      w_wa = 5'd9; w_wd = 32'hBB; w_pc = 32'h5104;
      tick();
      checks++; if (regwrite !== 1'b1 || wa !== 5'd9 || wd !== 32'hBB) begin
         failures++; $display("FAIL squash_w got rw=%0b wa=%0d wd=%h exp rw=1 wa=9 wd=bb", regwrite, wa, wd); end
      checks++; if (busy !== 32'd0 || count !== 3'd1) begin
         failures++; $display("FAIL squash_busy got busy=%h cnt=%0d exp busy=0 cnt=1", busy, count); end
      w_we = 1'b0;
      tick();
      checks++; if (regwrite !== 1'b0 || count !== 3'd0 || wd !== 32'hBB) begin
         failures++; $display("FAIL squash_drain got rw=%0b cnt=%0d wd=%h exp rw=0 cnt=0 wd=bb", regwrite, count, wd); end
      idle_inputs();
   endtask

   task automatic test_simultaneous();
      s_valid = 1'b1; s_wa = 5'd7; s_wd = 32'h1; s_pc = 32'h6000;
      w_we = 1'b1; w_wa = 5'd7; w_wd = 32'h2; w_pc = 32'h6100;
      tick();
      checks++; if (regwrite !== 1'b1 || wa !== 5'd7 || wd !== 32'h2 || busy !== 32'd0 || count !== 3'd1) begin
         failures++; $display("FAIL simul_w got rw=%0b wa=%0d wd=%h busy=%h cnt=%0d exp rw=1 wa=7 wd=2 busy=0 cnt=1", regwrite, wa, wd, busy, count); end
      s_valid = 1'b0; w_we = 1'b0;
      tick();
      checks++; if (regwrite !== 1'b0 || count !== 3'd0) begin
         failures++; $display("FAIL simul_drain got rw=%0b cnt=%0d exp rw=0 cnt=0", regwrite, count); end
      s_valid = 1'b1; s_wa = 5'd0; s_wd = 32'h33;
      w_we = 1'b1; w_wa = 5'd0; w_wd = 32'h44;
      checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL zero_ready got=%0b exp=1", s_ready); end
      tick();
      s_valid = 1'b0; w_we = 1'b0;
      checks++; if (regwrite !== 1'b0 || count !== 3'd0 || busy !== 32'd0) begin
         failures++; $display("FAIL zero_drop got rw=%0b cnt=%0d busy=%h exp rw=0 cnt=0 busy=0", regwrite, count, busy); end
      tick();
      checks++; if (regwrite !== 1'b0 || wd !== 32'h2) begin
         failures++; $display("FAIL zero_never got rw=%0b wd=%h exp rw=0 wd=2", regwrite, wd); end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      w_we = 1'b1; w_wa = 5'd2; w_wd = 32'h77; w_pc = 32'h7000;
      s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_wa = 5'(13 + i); s_wd = 32'(32'h900 + i); s_pc = 32'(32'h8000 + 4 * i);
         tick();
      end
      s_valid = 1'b0; w_we = 1'b0;
      tick();
      checks++; if (count !== 3'd3 || regwrite !== 1'b1 || wa !== 5'd13) begin
         failures++; $display("FAIL pre_reset got cnt=%0d rw=%0b wa=%0d exp cnt=3 rw=1 wa=13", count, regwrite, wa); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (regwrite !== 1'b0 || wa !== 5'd0 || wd !== 32'd0 || wpc !== 32'd0) begin
         failures++; $display("FAIL async_port got rw=%0b wa=%0d wd=%h wpc=%h exp all 0", regwrite, wa, wd, wpc); end
      checks++; if (count !== 3'd0 || busy !== 32'd0) begin
         failures++; $display("FAIL async_fifo got cnt=%0d busy=%h exp 0", count, busy); end
      @(negedge clk);
      rst = 1'b1;
      tick();
      checks++; if (regwrite !== 1'b0 || count !== 3'd0 || s_ready !== 1'b1) begin
         failures++; $display("FAIL post_reset got rw=%0b cnt=%0d s_ready=%0b exp rw=0 cnt=0 s_ready=1", regwrite, count, s_ready); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      idle_inputs();
      test_reset();
      test_w_only();
      test_fill_drain();
      test_squash();
      test_simultaneous();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
